// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- buffered 8N1 UART transmitter.
//
// Accepts bytes over a valid/ready handshake and holds them in a small FIFO.
// A serializer then drains the FIFO onto the serial line: one start bit
// (low), eight data bits sent LSB first, and one stop bit (high). Every bit
// lasts CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte entries in the queue (power of two, >= 2)
//
// Ports:
//   CLK       in   1  clock; all state updates on the rising edge
//   RST_N     in   1  asynchronous active-low reset
//   wr_valid  in   1  a byte is presented on wr_data
//   wr_data   in   8  byte to transmit
//   wr_ready  out  1  FIFO can take a byte this cycle (registered state only)
//   tx        out  1  serial line, idles high, driven from a flop
//   busy      out  1  FIFO non-empty or a frame in flight
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       tx,
    output logic       busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       fifo_head;

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]       bit_q;
    logic [2:0]       bit_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             tx_q;
    logic             tx_d;
    logic             baud_last;

    assign wr_ready   = (count_q != CNT_FULL);
    assign push       = wr_valid && wr_ready;
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign baud_last  = (baud_q == BAUD_LAST);

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) || !fifo_empty;

    // Pointers and occupancy. A simultaneous push and pop leaves count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset; reset empties the FIFO by clearing the
    // pointers and count, so stale entries are never read.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    // Next-state logic. tx_d is the line level for the state being entered,
    // so the registered tx lines up exactly with the registered state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end

            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                    tx_d   = 1'b0;
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        // Next bit is the one about to shift into position 0.
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                    tx_d   = shift_q[0];
                end
            end

            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                    tx_d   = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule
